// File: rtl/update_seq_pkg.sv
// Shared types and constants for the update sequencer: FSM states, step indices
// and the fixed step offsets.
package update_seq_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StExec, StDone} seq_state_e;

  typedef logic [1:0] step_idx_t;

  localparam step_idx_t StepA = 2'd0;  // a := b + c
  localparam step_idx_t StepD = 2'd1;  // d := a - DOffset
  localparam step_idx_t StepB = 2'd2;  // b := d + BOffset
  localparam step_idx_t StepC = 2'd3;  // c := c + 1

  localparam int unsigned DOffset = 3;
  localparam int unsigned BOffset = 10;

endpackage

// File: rtl/step_timer.sv
// STEP_DLY down-counter: load arms it, expire fires on the STEP_DLY-th run edge
// and the counter re-arms itself so steps follow back to back.
module step_timer #(
  parameter int unsigned STEP_DLY = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam logic [7:0] Reload = 8'(STEP_DLY - 1);

  logic [7:0] cnt_q, cnt_d;

  assign expire = run && (cnt_q == 8'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = Reload;
    end else if (run) begin
      cnt_d = expire ? Reload : cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/update_sequencer.sv
// Runs ITER passes of the four dependent register updates, one step every
// STEP_DLY cycles, with start/abort control and a done pulse.
module update_sequencer
  import update_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned STEP_DLY = 5,
  parameter int unsigned ITER     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_init,
  input  logic [WIDTH-1:0] b_init,
  input  logic [WIDTH-1:0] c_init,
  input  logic [WIDTH-1:0] d_init,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [1:0]       step,
  output logic [7:0]       iter
);

  localparam logic [7:0] IterMax = 8'(ITER);

  seq_state_e       state_q;
  step_idx_t        step_q;
  logic [7:0]       iter_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic [WIDTH-1:0] a_d, b_d, c_d, d_d;

  logic active, accept, run, expire, last_step;

  assign active = (state_q == StWait) || (state_q == StExec);
  // In DONE a start is always taken; in IDLE a simultaneous abort cancels it.
  assign accept = ((state_q == StIdle) && start && !abort) || ((state_q == StDone) && start);
  assign run = active && !abort;
  assign last_step = (step_q == StepC) && ((iter_q + 8'd1) == IterMax);

  step_timer #(
    .STEP_DLY(STEP_DLY)
  ) u_step_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .run   (run),
    .expire(expire)
  );

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    d_d = d_q;
    if (accept) begin
      a_d = a_init;
      b_d = b_init;
      c_d = c_init;
      d_d = d_init;
    end else if (expire) begin
      unique case (step_q)
        StepA:   a_d = b_q + c_q;
        StepD:   d_d = a_q - WIDTH'(DOffset);
        StepB:   b_d = d_q + WIDTH'(BOffset);
        default: c_d = c_q + WIDTH'(1);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= StepA;
      iter_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
    end else begin
      done_q <= 1'b0;
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      d_q    <= d_d;
      case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            state_q <= StWait;
            step_q  <= StepA;
            iter_q  <= 8'd0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StWait, StExec: begin
          if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (expire) begin
            step_q <= step_q + 2'd1;
            if (step_q == StepC) begin
              iter_q <= iter_q + 8'd1;
            end
            if (last_step) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StExec;
            end
          end else begin
            state_q <= StWait;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a    = a_q;
  assign b    = b_q;
  assign c    = c_q;
  assign d    = d_q;
  assign busy = busy_q;
  assign done = done_q;
  assign step = step_q;
  assign iter = iter_q;

endmodule

// File: tb/tb_update_sequencer.sv
// Directed bench for update_sequencer: a default 32-bit instance and an 8-bit
// single-pass instance for wrap-around.
module tb_update_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort, start8, abort8;
  logic [31:0] a_init, b_init, c_init, d_init, a, b, c, d;
  logic [7:0]  a8_init, b8_init, c8_init, d8_init, a8, b8, c8, d8;
  logic        busy, done, busy8, done8;
  logic [1:0]  step, step8;
  logic [7:0]  iter, iter8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  update_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a_init(a_init), .b_init(b_init), .c_init(c_init), .d_init(d_init),
    .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .step(step), .iter(iter)
  );

  update_sequencer #(.WIDTH(8), .STEP_DLY(5), .ITER(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8),
    .a_init(a8_init), .b_init(b8_init), .c_init(c8_init), .d_init(d8_init),
    .a(a8), .b(b8), .c(c8), .d(d8),
    .busy(busy8), .done(done8), .step(step8), .iter(iter8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_init(input int av, input int bv, input int cv, input int dv);
    a_init = 32'(av); b_init = 32'(bv); c_init = 32'(cv); d_init = 32'(dv);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; start8 = 1'b0; abort8 = 1'b0;
    set_init(0, 0, 0, 0);
    a8_init = 8'd0; b8_init = 8'd0; c8_init = 8'd0; d8_init = 8'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (a !== 32'd0) begin n_bad++; $display("FAIL reset_a: got %0d want 0", a); end
    n_cmp++; if (b !== 32'd0) begin n_bad++; $display("FAIL reset_b: got %0d want 0", b); end
    n_cmp++; if (c !== 32'd0) begin n_bad++; $display("FAIL reset_c: got %0d want 0", c); end
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL reset_d: got %0d want 0", d); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (step !== 2'd0) begin n_bad++; $display("FAIL reset_step: got %0d want 0", step); end
    n_cmp++; if (iter !== 8'd0) begin n_bad++; $display("FAIL reset_iter: got %0d want 0", iter); end
    n_cmp++; if (a8 !== 8'd0) begin n_bad++; $display("FAIL reset_a8: got %0d want 0", a8); end
  endtask

  task automatic test_full_run();
    int busy_bad = 0;
    int early = 0;
    set_init(30, 20, 15, 5);
    pulse_start();
    for (int e = 1; e <= 80; e++) begin
      if (busy !== 1'b1) busy_bad++;
      if (done !== 1'b0) early++;
      tick();
      if (e == 20) begin
        n_cmp++; if (a !== 32'd35) begin n_bad++; $display("FAIL pass1_a: got %0d want 35", a); end
        n_cmp++; if (d !== 32'd32) begin n_bad++; $display("FAIL pass1_d: got %0d want 32", d); end
        n_cmp++; if (b !== 32'd42) begin n_bad++; $display("FAIL pass1_b: got %0d want 42", b); end
        n_cmp++; if (c !== 32'd16) begin n_bad++; $display("FAIL pass1_c: got %0d want 16", c); end
        n_cmp++; if (iter !== 8'd1) begin n_bad++; $display("FAIL pass1_iter: got %0d want 1", iter); end
        n_cmp++; if (step !== 2'd0) begin n_bad++; $display("FAIL pass1_step: got %0d want 0", step); end
      end
      if (e == 40) begin
        n_cmp++; if (a !== 32'd58) begin n_bad++; $display("FAIL pass2_a: got %0d want 58", a); end
        n_cmp++; if (d !== 32'd55) begin n_bad++; $display("FAIL pass2_d: got %0d want 55", d); end
        n_cmp++; if (b !== 32'd65) begin n_bad++; $display("FAIL pass2_b: got %0d want 65", b); end
        n_cmp++; if (c !== 32'd17) begin n_bad++; $display("FAIL pass2_c: got %0d want 17", c); end
        n_cmp++; if (iter !== 8'd2) begin n_bad++; $display("FAIL pass2_iter: got %0d want 2", iter); end
      end
    end
    n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL run_busy_window: got %0d low cycles want 0", busy_bad); end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL run_early_done: got %0d pulses want 0", early); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL run_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL run_busy_at_done: got %b want 0", busy); end
    n_cmp++; if (a !== 32'd107) begin n_bad++; $display("FAIL run_a: got %0d want 107", a); end
    n_cmp++; if (b !== 32'd114) begin n_bad++; $display("FAIL run_b: got %0d want 114", b); end
    n_cmp++; if (c !== 32'd19) begin n_bad++; $display("FAIL run_c: got %0d want 19", c); end
    n_cmp++; if (d !== 32'd104) begin n_bad++; $display("FAIL run_d: got %0d want 104", d); end
    n_cmp++; if (iter !== 8'd4) begin n_bad++; $display("FAIL run_iter: got %0d want 4", iter); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL run_done_width: got %b want 0", done); end
    repeat (10) tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    n_cmp++; if (a !== 32'd107) begin n_bad++; $display("FAIL idle_hold_a: got %0d want 107", a); end
  endtask

  task automatic test_wrap();
    a8_init = 8'd0; b8_init = 8'd250; c8_init = 8'd255; d8_init = 8'd0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (5) tick();
    n_cmp++; if (a8 !== 8'd249) begin n_bad++; $display("FAIL wrap_step0_a: got %0d want 249", a8); end
    repeat (15) tick();
    n_cmp++; if (done8 !== 1'b1) begin n_bad++; $display("FAIL wrap_done: got %b want 1", done8); end
    n_cmp++; if (a8 !== 8'd249) begin n_bad++; $display("FAIL wrap_a: got %0d want 249", a8); end
    n_cmp++; if (d8 !== 8'd246) begin n_bad++; $display("FAIL wrap_d: got %0d want 246", d8); end
    n_cmp++; if (b8 !== 8'd0) begin n_bad++; $display("FAIL wrap_b: got %0d want 0", b8); end
    n_cmp++; if (c8 !== 8'd0) begin n_bad++; $display("FAIL wrap_c: got %0d want 0", c8); end
    n_cmp++; if (iter8 !== 8'd1) begin n_bad++; $display("FAIL wrap_iter: got %0d want 1", iter8); end
    tick();
  endtask

  task automatic test_abort();
    int pulses = 0;
    set_init(30, 20, 15, 5);
    pulse_start();
    repeat (36) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", done); end
    n_cmp++; if (a !== 32'd58) begin n_bad++; $display("FAIL abort_a: got %0d want 58", a); end
    n_cmp++; if (b !== 32'd65) begin n_bad++; $display("FAIL abort_b: got %0d want 65", b); end
    n_cmp++; if (c !== 32'd16) begin n_bad++; $display("FAIL abort_c: got %0d want 16", c); end
    n_cmp++; if (d !== 32'd55) begin n_bad++; $display("FAIL abort_d: got %0d want 55", d); end
    n_cmp++; if (step !== 2'd3) begin n_bad++; $display("FAIL abort_step: got %0d want 3", step); end
    n_cmp++; if (iter !== 8'd1) begin n_bad++; $display("FAIL abort_iter: got %0d want 1", iter); end
    for (int i = 0; i < 20; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
      tick();
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", pulses); end
    n_cmp++; if (a !== 32'd58) begin n_bad++; $display("FAIL abort_hold_a: got %0d want 58", a); end
    // start and abort together in IDLE: no load, no run
    set_init(1, 2, 3, 4);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_abort_busy: got %b want 0", busy); end
    n_cmp++; if (a !== 32'd58) begin n_bad++; $display("FAIL start_abort_a: got %0d want 58", a); end
    set_init(30, 20, 15, 5);
    pulse_start();
    n_cmp++; if (a !== 32'd30 || b !== 32'd20 || c !== 32'd15 || d !== 32'd5)
      begin n_bad++; $display("FAIL rerun_load: got %0d/%0d/%0d/%0d want 30/20/15/5", a, b, c, d); end
    n_cmp++; if (iter !== 8'd0 || step !== 2'd0)
      begin n_bad++; $display("FAIL rerun_clear: got iter %0d step %0d want 0/0", iter, step); end
    repeat (80) tick();
    n_cmp++; if (done !== 1'b1 || a !== 32'd107 || b !== 32'd114 || c !== 32'd19 || d !== 32'd104)
      begin n_bad++; $display("FAIL rerun_final: got done %b %0d/%0d/%0d/%0d want 1 107/114/19/104", done, a, b, c, d); end
    tick();
  endtask

  task automatic test_back_to_back();
    int early = 0;
    set_init(30, 20, 15, 5);
    pulse_start();
    set_init(999, 999, 999, 999);
    for (int e = 1; e <= 80; e++) begin
      if (e == 10 || e == 50) start = 1'b1;
      if (done !== 1'b0) early++;
      tick();
      start = 1'b0;
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL restart_early_done: got %0d want 0", early); end
    n_cmp++; if (done !== 1'b1 || a !== 32'd107 || b !== 32'd114 || c !== 32'd19 || d !== 32'd104)
      begin n_bad++; $display("FAIL restart_final: got done %b %0d/%0d/%0d/%0d want 1 107/114/19/104", done, a, b, c, d); end
    set_init(30, 20, 15, 5);
    pulse_start();
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0)
      begin n_bad++; $display("FAIL b2b_state: got busy %b done %b want 1/0", busy, done); end
    n_cmp++; if (a !== 32'd30 || iter !== 8'd0)
      begin n_bad++; $display("FAIL b2b_load: got a %0d iter %0d want 30/0", a, iter); end
    repeat (79) tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1)
      begin n_bad++; $display("FAIL b2b_edge79: got done %b busy %b want 0/1", done, busy); end
    tick();
    n_cmp++; if (done !== 1'b1 || a !== 32'd107 || d !== 32'd104)
      begin n_bad++; $display("FAIL b2b_final: got done %b a %0d d %0d want 1 107 104", done, a, d); end
    tick();
  endtask

  task automatic test_reset_mid();
    int active = 0;
    set_init(30, 20, 15, 5);
    pulse_start();
    repeat (24) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (a !== 32'd0 || b !== 32'd0 || c !== 32'd0 || d !== 32'd0)
      begin n_bad++; $display("FAIL midrst_regs: got %0d/%0d/%0d/%0d want 0/0/0/0", a, b, c, d); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || step !== 2'd0 || iter !== 8'd0)
      begin n_bad++; $display("FAIL midrst_ctrl: got busy %b done %b step %0d iter %0d want 0", busy, done, step, iter); end
    for (int i = 0; i < 100; i++) begin
      if (busy !== 1'b0 || done !== 1'b0 || a !== 32'd0) active++;
      tick();
    end
    n_cmp++; if (active != 0) begin n_bad++; $display("FAIL midrst_idle: got %0d active cycles want 0", active); end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
